// File: rtl/q_update_engine.sv
// q_update_engine: spline weight update q_k += ((mu*err)>>>FRAC * basis_k)>>>FRAC on one shared multiplier.
// Q_UPDATE_SAT_EN selects clamping with a sticky sat_flag; undefined, results wrap to WIDTH.
module q_update_engine #(
    parameter int WIDTH = 16,
    parameter int Q     = 13,
    parameter int Q_ORD = 4,
    parameter int FRAC  = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(Q+Q_ORD)-1:0] span_ind,
    input  logic signed [WIDTH-1:0]    err,
    input  logic signed [WIDTH-1:0]    mu,
    input  logic [Q_ORD*WIDTH-1:0]     basis_packed,
    input  logic [Q_ORD*WIDTH-1:0]     q_weight_old_packed,
    output logic [$clog2(Q+Q_ORD)-1:0] span_ind_write,
    output logic [$clog2(Q+Q_ORD)-1:0] span_ind_write_d,
    output logic [Q_ORD*WIDTH-1:0]     q_update_packed,
    output logic                       write_en,
    output logic                       busy,
    output logic                       span_err,
    output logic                       sat_flag
);
    localparam int AW = $clog2(Q+Q_ORD);
    localparam int KW = (Q_ORD > 1) ? $clog2(Q_ORD) : 1;
    localparam int PW = 2*WIDTH;
    localparam logic [AW-1:0] QMAX  = AW'(Q);
    localparam logic [KW-1:0] KLAST = KW'(Q_ORD-1);
    localparam logic signed [PW-1:0] MAXV = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`ifdef Q_UPDATE_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif
    localparam logic [1:0] IDLE = 2'd0, GAIN = 2'd1, MAC = 2'd2, WRITE = 2'd3;

    function automatic logic ovf(input logic signed [PW-1:0] x);
        return (x > MAXV) || (x < MINV);
    endfunction

    function automatic logic [WIDTH-1:0] lim(input logic signed [PW-1:0] x);
        return (SAT && x > MAXV) ? MAXV[WIDTH-1:0] : (SAT && x < MINV) ? MINV[WIDTH-1:0] : x[WIDTH-1:0];
    endfunction

    logic [1:0]              state_q, state_d;
    logic [KW-1:0]           k_q;
    logic signed [WIDTH-1:0] g_q, mu_q, err_q;
    logic [Q_ORD*WIDTH-1:0]  basis_q, acc_q, upd_q, nxt;
    logic [AW-1:0]           addr_q, wa_q;
    logic                    span_err_q, sat_q;
    logic signed [WIDTH-1:0] ma, mb, ok, term, nw;
    logic signed [PW-1:0]    sh, sum;

    // GAIN borrows the MAC multiplier for mu*err; MAC cycles use g*basis_k
    always_comb begin
        ma = (state_q == GAIN) ? mu_q : g_q;
        mb = (state_q == GAIN) ? err_q : basis_q[k_q*WIDTH +: WIDTH];
        sh = (PW'(ma) * PW'(mb)) >>> FRAC;
        term = lim(sh);
        ok = q_weight_old_packed[k_q*WIDTH +: WIDTH];
        sum = PW'(ok) + PW'(term);
        nw = lim(sum);
        nxt = acc_q;
        nxt[k_q*WIDTH +: WIDTH] = nw;
        state_d = (state_q == IDLE) ? ((start && span_ind <= QMAX) ? GAIN : IDLE) :
                  (state_q == GAIN) ? MAC :
                  (state_q == MAC)  ? ((k_q == KLAST) ? WRITE : MAC) : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            k_q        <= '0;
            g_q        <= '0;
            mu_q       <= '0;
            err_q      <= '0;
            basis_q    <= '0;
            acc_q      <= '0;
            upd_q      <= '0;
            addr_q     <= '0;
            wa_q       <= '0;
            span_err_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            span_err_q <= (state_q == IDLE) && start && (span_ind > QMAX);
            if (state_q == IDLE && state_d == GAIN) begin
                addr_q  <= span_ind;
                mu_q    <= mu;
                err_q   <= err;
                basis_q <= basis_packed;
                sat_q   <= 1'b0;
            end
            if (state_q == GAIN) begin
                g_q   <= term;
                k_q   <= '0;
                sat_q <= sat_q | (SAT & ovf(sh));
            end
            if (state_q == MAC) begin
                acc_q <= nxt;
                k_q   <= (k_q == KLAST) ? '0 : k_q + 1'b1;
                sat_q <= sat_q | (SAT & (ovf(sh) | ovf(sum)));
            end
            if (state_q == MAC && k_q == KLAST) begin
                upd_q <= nxt;
                wa_q  <= addr_q;
            end
        end
    end

    assign span_ind_write   = addr_q;
    assign span_ind_write_d = wa_q;
    assign q_update_packed  = upd_q;
    assign write_en         = (state_q == WRITE);
    assign busy             = (state_q != IDLE);
    assign span_err         = span_err_q;
    assign sat_flag         = sat_q;
endmodule

// File: tb/tb_q_update_engine.sv
// tb_q_update_engine: table vectors, corner sequences and randomized updates checked against an arithmetic model.
`timescale 1ns/1ps
module tb_q_update_engine;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [4:0]  span_ind = '0;
    logic [15:0] err = '0, mu = '0;
    logic [63:0] basis_packed = '0, q_weight_old_packed;
    logic [4:0]  span_ind_write, span_ind_write_d;
    logic [63:0] q_update_packed;
    logic        write_en, busy, span_err, sat_flag;
    logic [63:0] mem [32];
    int          n_chk = 0, n_fail = 0;
`ifdef Q_UPDATE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [4:0]  span;
        logic [15:0] mu, err;
        logic [63:0] basis, old, q;
        logic        sat;
    } vec_t;

    always #5 clk = ~clk;
    assign q_weight_old_packed = mem[span_ind_write];

    q_update_engine dut (
        .clk(clk), .reset(reset), .start(start), .span_ind(span_ind), .err(err), .mu(mu),
        .basis_packed(basis_packed), .q_weight_old_packed(q_weight_old_packed),
        .span_ind_write(span_ind_write), .span_ind_write_d(span_ind_write_d),
        .q_update_packed(q_update_packed), .write_en(write_en), .busy(busy),
        .span_err(span_err), .sat_flag(sat_flag)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    // s records any out-of-range intermediate; only meaningful when clamping is built in
    function automatic longint lim(input longint v, inout bit s);
        if (v > 32767 || v < -32768) s = 1'b1;
`ifdef Q_UPDATE_SAT_EN
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
`else
        return ((v + 32768) & 64'hFFFF) - 32768;
`endif
    endfunction

    function automatic void model(input logic [63:0] b, o, input logic [15:0] m, e,
                                  output logic [63:0] q, output logic sat);
        bit s = 1'b0;
        longint g, t, n;
        g = lim((longint'($signed(m)) * longint'($signed(e))) >>> 12, s);
        for (int k = 0; k < 4; k++) begin
            t = lim((g * longint'($signed(b[16*k +: 16]))) >>> 12, s);
            n = lim(longint'($signed(o[16*k +: 16])) + t, s);
            q[16*k +: 16] = n[15:0];
        end
        sat = SAT & s;
    endfunction

    function automatic logic [15:0] rnd16();
        logic [15:0] r = 16'($urandom);
        return $urandom_range(0, 1) ? r : {{4{r[11]}}, r[11:0]};
    endfunction

    task automatic do_vec(input string nm, input vec_t v, input bit hold);
        int lat, nw;
        logic [63:0] qw;
        mem[v.span] = v.old;
        @(negedge clk);
        span_ind = v.span; mu = v.mu; err = v.err; basis_packed = v.basis; start = 1'b1;
        @(posedge clk); #1;
        lat = 0; nw = 0; qw = '0;
        for (int c = 1; c <= 12; c++) begin
            start = hold && c <= 6;
            span_ind = 5'($urandom); mu = 16'($urandom); err = 16'($urandom);
            basis_packed = {$urandom, $urandom};
            if (c == 1 || c == 7) chk({nm, " busy"}, 64'(busy), 64'(c == 1));
            if (write_en) begin
                nw++;
                if (lat == 0) begin
                    lat = c;
                    qw = q_update_packed;
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({nm, " latency"}, lat, 6);
        chk({nm, " writes"}, nw, 1);
        chk({nm, " addr"}, span_ind_write_d, v.span);
        chk({nm, " q at write"}, qw, v.q);
        chk({nm, " q held"}, q_update_packed, v.q);
        chk({nm, " sat"}, sat_flag, v.sat);
    endtask

    task automatic quiet(input string nm, input int n);
        int w = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (write_en) w++;
        end
        chk({nm, " no write"}, w, 0);
    endtask

    initial begin
        vec_t vt[6];
        vec_t v;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        vt[0] = '{5'd6, 16'h0100, 16'h1000, 64'h0000_0000_0000_1000, 64'h0C00_0800_0400_0000, 64'h0C00_0800_0400_0100, 1'b0};
        vt[2] = '{5'd0, 16'h1000, 16'hF000, 64'h0000_0000_0000_0800, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_F800, 1'b0};
        vt[3] = '{5'd3, 16'h0800, 16'h0800, 64'h1000_0800_F000_2000, 64'h0100_0200_0300_0400, 64'h0500_0400_FF00_0C00, 1'b0};
        vt[4] = '{5'd1, 16'hFFFF, 16'h0001, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0010, 64'h0000_0000_0000_000F, 1'b0};
`ifdef Q_UPDATE_SAT_EN
        vt[1] = '{5'd13, 16'h7FFF, 16'h7FFF, 64'h1000_0000_0000_0000, 64'h2800_0000_0000_0000, 64'h7FFF_0000_0000_0000, 1'b1};
        vt[5] = '{5'd2, 16'h1000, 16'h7000, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_7000, 64'h0000_0000_0000_7FFF, 1'b1};
`else
        vt[1] = '{5'd13, 16'h7FFF, 16'h7FFF, 64'h1000_0000_0000_0000, 64'h2800_0000_0000_0000, 64'h27F0_0000_0000_0000, 1'b0};
        vt[5] = '{5'd2, 16'h1000, 16'h7000, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_7000, 64'h0000_0000_0000_E000, 1'b0};
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset ctl", {busy, write_en, span_err, sat_flag, span_ind_write, span_ind_write_d}, 64'h0);
        chk("reset q", q_update_packed, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) do_vec($sformatf("vec%0d", i), vt[i], i == 3);

        @(negedge clk);
        span_ind = 5'd14; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("span_err pulse", span_err, 1'b1);
        chk("span_err busy", busy, 1'b0);
        @(posedge clk); #1;
        chk("span_err clear", span_err, 1'b0);
        quiet("span_err", 8);

        mem[9] = 64'h1111_2222_3333_4444;
        @(negedge clk);
        span_ind = 5'd9; mu = 16'h0100; err = 16'h1000; basis_packed = 64'h1000_1000_1000_1000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        chk("midreset ctl", {busy, write_en, span_err, sat_flag, span_ind_write, span_ind_write_d}, 64'h0);
        chk("midreset q", q_update_packed, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        quiet("midreset", 10);
        do_vec("after reset", vt[0], 1'b0);

        for (int i = 0; i < 40; i++) begin
            v.span = 5'($urandom_range(0, 13));
            v.mu = rnd16();
            v.err = rnd16();
            for (int k = 0; k < 4; k++) begin
                v.basis[16*k +: 16] = rnd16();
                v.old[16*k +: 16] = rnd16();
            end
            model(v.basis, v.old, v.mu, v.err, v.q, v.sat);
            do_vec($sformatf("rand%0d", i), v, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
